// File: rtl/blake2b_ctrl.sv
// blake2b_ctrl: message framing controller in front of a BLAKE2b-512 core.
// Packs 64-bit message words (first byte in bits [63:56]) into 1024-bit blocks,
// tracks the cumulative byte count, and issues init/next/final command pulses.
// Optional: define BLAKE2B_CTRL_TIMEOUT_EN to bound every core wait to TIMEOUT
// cycles and add an error output.
//
// state       | meaning
// ------------+---------------------------------------------------
// S_IDLE      | no message in progress; waiting for start
// S_INIT      | waiting for ready_512 to issue init_512
// S_FILL      | accepting message words into the block
// S_NEXT      | full non-final block; waiting to issue next_512
// S_FINAL     | last block assembled; waiting to issue final_512
// S_WAIT_DGST | waiting for core_digest_valid
// S_DONE      | digest captured; digest_valid high
module blake2b_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [63:0]   in_data,
   input  logic          in_last,
   input  logic [3:0]    in_bytes,
   output logic          init_512,
   output logic          next_512,
   output logic          final_512,
   output logic [1023:0] block,
   output logic [127:0]  length_512,
   input  logic          ready_512,
   input  logic [511:0]  core_digest,
   input  logic          core_digest_valid,
   output logic [511:0]  digest_512,
   output logic          digest_valid,
`ifdef BLAKE2B_CTRL_TIMEOUT_EN
   output logic          error,
`endif
   output logic          busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_FILL, S_NEXT, S_FINAL, S_WAIT_DGST, S_DONE
   } state_t;

   state_t          state_q;
   logic [1023:0]   block_q;
   logic [127:0]    len_q;
   logic [3:0]      idx_q;
   logic            first_q;
   logic [511:0]    digest_q;
   logic            init_q, next_q, final_q;

   logic            empty_msg;
   logic [3:0]      nbytes;
   logic [63:0]     word_masked;
   logic [1023:0]   fill_block;

`ifdef BLAKE2B_CTRL_TIMEOUT_EN
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   logic [CW-1:0]   wait_q;
   logic            error_q;
   logic            waiting, wait_hit;

   // Which states are waiting on the core, and whether the awaited event is present.
   always_comb begin
      waiting  = (state_q == S_INIT) || (state_q == S_NEXT) ||
                 (state_q == S_FINAL) || (state_q == S_WAIT_DGST);
      wait_hit = (state_q == S_WAIT_DGST) ? core_digest_valid : ready_512;
   end

   assign error = error_q;
`else
   // TIMEOUT has no effect when the timeout option is not built in.
   logic timeout_unused;
   assign timeout_unused = (TIMEOUT != 0);
`endif

   // Byte count and masked word for an accepted beat, and the block it produces.
   // After next_512 the old block stays visible for the pulse cycle and is
   // replaced by zeros (plus any word accepted in that cycle) at the next edge.
   always_comb begin
      empty_msg = in_last && (in_bytes == 4'd0) && first_q && (idx_q == 4'd0);
      if (!in_last || (in_bytes == 4'd0) || (in_bytes > 4'd8)) nbytes = 4'd8;
      else                                                   nbytes = in_bytes;
      if (empty_msg) nbytes = 4'd0;
      for (int b = 0; b < 8; b++)
         word_masked[63-8*b -: 8] = (b < int'(nbytes)) ? in_data[63-8*b -: 8] : 8'h00;
      fill_block = next_q ? '0 : block_q;
      fill_block[1023 - 64*int'(idx_q) -: 64] = word_masked;
   end

   // Sequencing FSM with registered command pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         block_q  <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         first_q  <= 1'b0;
         digest_q <= '0;
         init_q   <= 1'b0;
         next_q   <= 1'b0;
         final_q  <= 1'b0;
`ifdef BLAKE2B_CTRL_TIMEOUT_EN
         wait_q   <= CW'(TIMEOUT);
         error_q  <= 1'b0;
`endif
      end else begin
         init_q  <= 1'b0;
         next_q  <= 1'b0;
         final_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q <= S_INIT;
                  block_q <= '0;
                  len_q   <= '0;
                  idx_q   <= '0;
                  first_q <= 1'b1;
               end
            end
            S_INIT: begin
               if (ready_512) begin
                  init_q  <= 1'b1;
                  state_q <= S_FILL;
               end
            end
            S_FILL: begin
               if (in_valid) begin
                  block_q <= fill_block;
                  len_q   <= len_q + {124'd0, nbytes};
                  idx_q   <= idx_q + 4'd1;
                  if (in_last)               state_q <= S_FINAL;
                  else if (idx_q == 4'd15)   state_q <= S_NEXT;
               end else if (next_q) begin
                  block_q <= '0;
               end
            end
            S_NEXT: begin
               if (ready_512) begin
                  next_q  <= 1'b1;
                  idx_q   <= '0;
                  first_q <= 1'b0;
                  state_q <= S_FILL;
               end
            end
            S_FINAL: begin
               if (ready_512) begin
                  final_q <= 1'b1;
                  state_q <= S_WAIT_DGST;
               end
            end
            S_WAIT_DGST: begin
               if (core_digest_valid) begin
                  digest_q <= core_digest;
                  state_q  <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
`ifdef BLAKE2B_CTRL_TIMEOUT_EN
         if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) error_q <= 1'b0;
         if (!waiting || wait_hit) begin
            wait_q <= CW'(TIMEOUT);
         end else if (wait_q <= CW'(1)) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
         end else begin
            wait_q <= wait_q - 1'b1;
         end
`endif
      end
   end

   assign in_ready     = (state_q == S_FILL);
   assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
   assign digest_valid = (state_q == S_DONE);
   assign init_512     = init_q;
   assign next_512     = next_q;
   assign final_512    = final_q;
   assign block        = block_q;
   assign length_512   = len_q;
   assign digest_512   = digest_q;

endmodule
